// File: rtl/rf_arb_pkg.sv
// ---------------------------------------------------------------------------
// rf_arb_pkg
// Shared types and constants for the register-file writeback arbiter.
//   XLEN       data width of a writeback
//   NREG       number of architectural registers
//   REG_IDX_W  register index width
//   wb_src_e   which writeback source won arbitration this cycle
//   wb_req_t   one writeback request (valid, destination, data)
// ---------------------------------------------------------------------------
package rf_arb_pkg;

  localparam int XLEN      = 32;
  localparam int NREG      = 32;
  localparam int REG_IDX_W = 5;

  typedef enum logic [1:0] {
    WB_NONE = 2'd0,
    WB_ALU  = 2'd1,
    WB_MEM  = 2'd2
  } wb_src_e;

  typedef struct packed {
    logic                 valid;
    logic [REG_IDX_W-1:0] rd;
    logic [XLEN-1:0]      data;
  } wb_req_t;

endpackage

// File: rtl/rf_scoreboard.sv
// ---------------------------------------------------------------------------
// rf_scoreboard
// One busy bit per architectural register. A bit is set when an instruction
// that writes the register issues and is cleared when the register file
// captures the write. Register 0 is never busy.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   set_en, set_idx     mark a destination busy at this edge
//   clr_en, clr_idx     mark a destination free at this edge
//   rs1, rs2, rd, wen   operands of the instruction in decode
//   issue_ready         no RAW on rs1/rs2 and no WAW on rd
//   busy_mask           current busy vector
// ---------------------------------------------------------------------------
module rf_scoreboard
  import rf_arb_pkg::*;
#(
  parameter int NREG_P = rf_arb_pkg::NREG
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 set_en,
  input  logic [REG_IDX_W-1:0] set_idx,
  input  logic                 clr_en,
  input  logic [REG_IDX_W-1:0] clr_idx,
  input  logic [REG_IDX_W-1:0] rs1,
  input  logic [REG_IDX_W-1:0] rs2,
  input  logic [REG_IDX_W-1:0] rd,
  input  logic                 wen,
  output logic                 issue_ready,
  output logic [NREG_P-1:0]    busy_mask
);

  logic [NREG_P-1:0] busy_q;
  logic [NREG_P-1:0] busy_d;

  // Next busy vector: clear first so a coincident set on the same index wins.
  always_comb begin
    busy_d = busy_q;
    if (clr_en) begin
      busy_d[clr_idx] = 1'b0;
    end else begin
      busy_d = busy_q;
    end
    if (set_en) begin
      busy_d[set_idx] = 1'b1;
    end else begin
      busy_d[0] = busy_d[0];
    end
    busy_d[0] = 1'b0;
  end

  // Busy vector register.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q <= {NREG_P{1'b0}};
    end else begin
      busy_q <= busy_d;
    end
  end

  assign issue_ready = !busy_q[rs1] && !busy_q[rs2] && !(wen && busy_q[rd]);
  assign busy_mask   = busy_q;

endmodule

// File: rtl/rf_wb_arbiter.sv
// ---------------------------------------------------------------------------
// rf_wb_arbiter
// Merges the ALU and load writeback streams onto the register file's single
// registered write port and stalls decode on RAW/WAW hazards.
// Build option:
//   RF_WB_ARB_RR_EN  defined   -> round-robin between ALU and mem on conflict
//                    undefined -> fixed priority, mem over ALU
// Ports:
//   clk, reset                        clock, synchronous active-high reset
//   issue_valid/wen/rd/rs1/rs2        decode-stage instruction
//   issue_ready                       combinational, no hazard
//   alu_wb_valid/rd/data, alu_wb_ready  ALU writeback handshake
//   mem_wb_valid/rd/data, mem_wb_ready  load writeback handshake
//   RegWrite, Rd, Write_data          registered register-file write port
//   busy_mask                         busy bit per register (bit 0 always 0)
// ---------------------------------------------------------------------------
module rf_wb_arbiter
  import rf_arb_pkg::*;
#(
  parameter int XLEN_P = rf_arb_pkg::XLEN,
  parameter int NREG_P = rf_arb_pkg::NREG
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 issue_valid,
  input  logic                 issue_wen,
  input  logic [REG_IDX_W-1:0] issue_rd,
  input  logic [REG_IDX_W-1:0] issue_rs1,
  input  logic [REG_IDX_W-1:0] issue_rs2,
  output logic                 issue_ready,
  input  logic                 alu_wb_valid,
  input  logic [REG_IDX_W-1:0] alu_wb_rd,
  input  logic [XLEN_P-1:0]    alu_wb_data,
  output logic                 alu_wb_ready,
  input  logic                 mem_wb_valid,
  input  logic [REG_IDX_W-1:0] mem_wb_rd,
  input  logic [XLEN_P-1:0]    mem_wb_data,
  output logic                 mem_wb_ready,
  output logic                 RegWrite,
  output logic [REG_IDX_W-1:0] Rd,
  output logic [XLEN_P-1:0]    Write_data,
  output logic [NREG_P-1:0]    busy_mask
);

  wb_req_t alu_req_s;
  wb_req_t mem_req_s;
  wb_req_t gnt_req_s;
  wb_src_e gnt_src_s;

  logic                 regwrite_q, regwrite_d;
  logic [REG_IDX_W-1:0] rd_q, rd_d;
  logic [XLEN_P-1:0]    wdata_q, wdata_d;
  logic                 issue_ready_s;
  logic                 set_en_s;

  assign alu_req_s = '{valid: alu_wb_valid, rd: alu_wb_rd, data: alu_wb_data};
  assign mem_req_s = '{valid: mem_wb_valid, rd: mem_wb_rd, data: mem_wb_data};

`ifdef RF_WB_ARB_RR_EN
  // Pointer: 0 favours ALU, 1 favours mem on the next conflict.
  logic ptr_q, ptr_d;

  // Pointer register; reset favours the ALU.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`endif

  // Source selection; only a conflict consults (and flips) the pointer.
  always_comb begin
    gnt_src_s = WB_NONE;
`ifdef RF_WB_ARB_RR_EN
    ptr_d = ptr_q;
`endif
    case ({alu_req_s.valid, mem_req_s.valid})
      2'b10: gnt_src_s = WB_ALU;
      2'b01: gnt_src_s = WB_MEM;
      2'b11: begin
`ifdef RF_WB_ARB_RR_EN
        if (ptr_q == 1'b0) begin
          gnt_src_s = WB_ALU;
        end else begin
          gnt_src_s = WB_MEM;
        end
        ptr_d = ~ptr_q;
`else
        gnt_src_s = WB_MEM;
`endif
      end
      default: gnt_src_s = WB_NONE;
    endcase
  end

  // Granted request and next output-register contents; no grant holds Rd/data.
  always_comb begin
    gnt_req_s = '{valid: 1'b0, rd: rd_q, data: wdata_q};
    case (gnt_src_s)
      WB_ALU:  gnt_req_s = alu_req_s;
      WB_MEM:  gnt_req_s = mem_req_s;
      default: gnt_req_s = '{valid: 1'b0, rd: rd_q, data: wdata_q};
    endcase
    regwrite_d = gnt_req_s.valid && (gnt_req_s.rd != {REG_IDX_W{1'b0}});
    rd_d       = gnt_req_s.rd;
    wdata_d    = gnt_req_s.data;
  end

  // Register-file write port register.
  always_ff @(posedge clk) begin
    if (reset) begin
      regwrite_q <= 1'b0;
      rd_q       <= {REG_IDX_W{1'b0}};
      wdata_q    <= {XLEN_P{1'b0}};
    end else begin
      regwrite_q <= regwrite_d;
      rd_q       <= rd_d;
      wdata_q    <= wdata_d;
    end
  end

  assign alu_wb_ready = (gnt_src_s == WB_ALU);
  assign mem_wb_ready = (gnt_src_s == WB_MEM);
  assign RegWrite     = regwrite_q;
  assign Rd           = rd_q;
  assign Write_data   = wdata_q;

  assign set_en_s = issue_valid && issue_ready_s && issue_wen &&
                    (issue_rd != {REG_IDX_W{1'b0}});

  // The busy bit clears on the edge where the register file captures the write.
  rf_scoreboard #(
    .NREG_P(NREG_P)
  ) u_scoreboard (
    .clk        (clk),
    .reset      (reset),
    .set_en     (set_en_s),
    .set_idx    (issue_rd),
    .clr_en     (regwrite_q),
    .clr_idx    (rd_q),
    .rs1        (issue_rs1),
    .rs2        (issue_rs2),
    .rd         (issue_rd),
    .wen        (issue_wen),
    .issue_ready(issue_ready_s),
    .busy_mask  (busy_mask)
  );

  assign issue_ready = issue_ready_s;

endmodule
